// File: rtl/pipe_adder_pkg.sv
// Shared helpers for pipe_adder: configuration legality, slice width and saturation limits.
package pipe_adder_pkg;

    localparam int unsigned MaxWidth = 1024;

    function automatic logic legal_config(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Bits handled per stage; zero for an illegal depth so elaboration fails cleanly.
    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    function automatic logic [MaxWidth-1:0] MAX_S(input int unsigned width);
        logic [MaxWidth-1:0] lim;
        lim = '0;
        for (int unsigned i = 0; i + 1 < width; i++) begin
            lim[i] = 1'b1;
        end
        return lim;
    endfunction

    function automatic logic [MaxWidth-1:0] MIN_S(input int unsigned width);
        logic [MaxWidth-1:0] lim;
        lim = '0;
        lim[width-1] = 1'b1;
        return lim;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational slice adder; also exposes the carry into its MSB for overflow detection.
module adder_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_msb_cin
);

    logic w_c_msb;

    if (WIDTH == 1) begin : g_bit
        assign w_c_msb = i_cin;
    end else begin : g_wide
        logic [WIDTH-1:0] w_low;
        assign w_low = {1'b0, i_a[WIDTH-2:0]} + {1'b0, i_b[WIDTH-2:0]} + WIDTH'(i_cin);
        assign w_c_msb = w_low[WIDTH-1];
        assign o_sum[WIDTH-2:0] = w_low[WIDTH-2:0];
    end

    assign o_sum[WIDTH-1] = i_a[WIDTH-1] ^ i_b[WIDTH-1] ^ w_c_msb;
    assign o_cout = (i_a[WIDTH-1] & i_b[WIDTH-1]) | (w_c_msb & (i_a[WIDTH-1] ^ i_b[WIDTH-1]));
    assign o_msb_cin = w_c_msb;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined signed adder/subtractor, one WIDTH/STAGES-bit slice per stage, global-stall flow control.
// Optional saturation on signed overflow when PIPE_ADDER_SAT_EN is defined.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] add,
    output logic             Co,
    output logic             ovf
);

    localparam int unsigned S = slice_width(WIDTH, STAGES);
    localparam int unsigned L = STAGES - 1;

    if (!legal_config(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    logic [WIDTH-1:0] w_a_in     [STAGES];
    logic [WIDTH-1:0] w_b_in     [STAGES];
    logic [WIDTH-1:0] w_sum_in   [STAGES];
    logic [WIDTH-1:0] w_sum_out  [STAGES];
    logic             w_c_in     [STAGES];
    logic             w_v_in     [STAGES];
    logic [S-1:0]     w_slice_sum[STAGES];
    logic             w_cout     [STAGES];
    logic             w_msb_cin  [STAGES];

    logic             w_ovf;
    logic [WIDTH-1:0] w_result;

    // Operand/result words travel whole; each stage only touches its own slice.
    logic [WIDTH-1:0] r_a    [STAGES];
    logic [WIDTH-1:0] r_b    [STAGES];
    logic [WIDTH-1:0] r_sum  [STAGES];
    logic             r_carry[STAGES];
    logic             r_valid[STAGES];
    logic             r_ovf;

    assign w_adv   = !r_valid[L] || out_ready;
    assign w_b_eff = sub ? ~inB : inB;
    assign w_c0    = sub ^ Cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SliceMask = WIDTH'({S{1'b1}}) << (k * S);

        if (k == 0) begin : g_first
            assign w_a_in[k]   = inA;
            assign w_b_in[k]   = w_b_eff;
            assign w_c_in[k]   = w_c0;
            assign w_v_in[k]   = in_valid;
            assign w_sum_in[k] = '0;
        end else begin : g_next
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_c_in[k]   = r_carry[k-1];
            assign w_v_in[k]   = r_valid[k-1];
            assign w_sum_in[k] = r_sum[k-1];
        end

        adder_slice #(
            .WIDTH (S)
        ) u_slice (
            .i_a       (w_a_in[k][k*S +: S]),
            .i_b       (w_b_in[k][k*S +: S]),
            .i_cin     (w_c_in[k]),
            .o_sum     (w_slice_sum[k]),
            .o_cout    (w_cout[k]),
            .o_msb_cin (w_msb_cin[k])
        );

        assign w_sum_out[k] = (w_sum_in[k] & ~SliceMask) |
                              (WIDTH'(w_slice_sum[k]) << (k * S));
    end

    // Carry into the MSB differing from carry out of it is exactly signed overflow.
    assign w_ovf = w_cout[L] ^ w_msb_cin[L];

`ifdef PIPE_ADDER_SAT_EN
    always_comb begin
        w_result = w_sum_out[L];
        if (w_ovf) begin
            w_result = w_a_in[L][WIDTH-1] ? WIDTH'(MIN_S(WIDTH)) : WIDTH'(MAX_S(WIDTH));
        end
    end
`else
    assign w_result = w_sum_out[L];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
                r_valid[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                r_a[k]     <= w_a_in[k];
                r_b[k]     <= w_b_in[k];
                r_sum[k]   <= (k == int'(L)) ? w_result : w_sum_out[k];
                r_carry[k] <= w_cout[k];
                r_valid[k] <= w_v_in[k];
            end
            r_ovf <= w_ovf;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_valid[L];
    assign add       = r_sum[L];
    assign Co        = r_carry[L];
    assign ovf       = r_ovf;

endmodule
